// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-FF synchroniser, stability-window FSM, debounced level and edge pulses.
// Optional long-press pulse is enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer #(
   parameter longint unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter longint unsigned DEBOUNCE_TIME_IN_MS         = 10,
   parameter longint unsigned LONG_PRESS_TIME_IN_MS       = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press_pulse
);

   localparam longint unsigned DEB_RAW  = BOARD_CLOCK_FREQUENCY_IN_HZ * DEBOUNCE_TIME_IN_MS / 64'd1000;
   localparam longint unsigned LONG_RAW = BOARD_CLOCK_FREQUENCY_IN_HZ * LONG_PRESS_TIME_IN_MS / 64'd1000;
   localparam longint unsigned DEB_CYC  = (DEB_RAW  < 64'd1) ? 64'd1 : DEB_RAW;
   localparam longint unsigned LONG_CYC = (LONG_RAW < 64'd1) ? 64'd1 : LONG_RAW;
   localparam longint unsigned MAX_CYC  = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
   localparam int              CNT_W    = $clog2(MAX_CYC + 64'd1);

   localparam logic [CNT_W-1:0] DEB_CNT  = CNT_W'(DEB_CYC);
   localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_CYC);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   localparam logic [1:0] RELEASED     = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   logic             s1;
   logic             s2;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;

   // The single counter times both debounce windows and, while PRESSED, the hold time.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         state         <= RELEASED;
         cnt           <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
         long_press_pulse <= 1'b0;
`endif
      end else begin
         s1            <= btn_in;
         s2            <= s1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
         long_press_pulse <= 1'b0;
`endif
         case (state)
            RELEASED: begin
               if (s2) begin
                  state <= PRESS_WAIT;
                  cnt   <= ONE;
               end
            end
            PRESS_WAIT: begin
               if (!s2) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == DEB_CNT) begin
                  state       <= PRESSED;
                  cnt         <= '0;
                  btn_level   <= 1'b1;
                  press_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            PRESSED: begin
               if (!s2) begin
                  state <= RELEASE_WAIT;
                  cnt   <= ONE;
               end else if (cnt != LONG_CNT) begin
                  cnt <= cnt + ONE;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
                  if (cnt == LONG_CNT - ONE) begin
                     long_press_pulse <= 1'b1;
                  end
`endif
               end
            end
            RELEASE_WAIT: begin
               // Returning to PRESSED restarts the hold timer but is not a new press.
               if (s2) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == DEB_CNT) begin
                  state         <= RELEASED;
                  cnt           <= '0;
                  btn_level     <= 1'b0;
                  release_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifndef BUTTON_DEBOUNCER_LONG_PRESS_EN
   assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with DEB_CYC=4 and LONG_CYC=10.
// Expected vectors are {btn_level, press_pulse, release_pulse, long_press_pulse}.
module tb_button_debouncer;

   logic clk;
   logic rst;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic long_press_pulse;

   int assertCount = 0;
   int failCount   = 0;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   button_debouncer #(
      .BOARD_CLOCK_FREQUENCY_IN_HZ(64'd1000),
      .DEBOUNCE_TIME_IN_MS(64'd4),
      .LONG_PRESS_TIME_IN_MS(64'd10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .btn_level(btn_level),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .long_press_pulse(long_press_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic b, input logic r);
      btn_in = b;
      rst    = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] expected);
      logic [3:0] observed;
      observed = {btn_level, press_pulse, release_pulse, long_press_pulse};
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Advance n cycles, checking the same output vector after each edge.
   task automatic runSteady(input string tag, input int n, input logic [3:0] expected);
      for (int i = 0; i < n; i++) begin
         tick();
         checkOutput(tag, expected);
      end
   endtask

   initial begin
      logic [3:0] bouncePattern [7];
      logic [3:0] holdExp;

      // Reset held with the button pressed: everything stays cleared.
      applyStimulus(1'b1, 1'b1);
      runSteady("reset", 3, 4'b0000);

      // Reset released with button held: press on the 7th edge (k+6).
      applyStimulus(1'b1, 1'b0);
      runSteady("rst_release_wait", 6, 4'b0000);
      tick(); checkOutput("rst_release_press", 4'b1100);
      tick(); checkOutput("rst_release_after", 4'b1000);

      applyStimulus(1'b0, 1'b0);
      runSteady("release1_wait", 6, 4'b1000);
      tick(); checkOutput("release1_pulse", 4'b0010);
      tick(); checkOutput("release1_after", 4'b0000);

      // Clean press from idle, then hold for 30 cycles to exercise long press.
      applyStimulus(1'b1, 1'b0);
      runSteady("press_wait", 6, 4'b0000);
      tick(); checkOutput("press_pulse", 4'b1100);
      for (int i = 1; i <= 30; i++) begin
         holdExp = (i == 10 && LONG_EN) ? 4'b1001 : 4'b1000;
         tick(); checkOutput("long_hold", holdExp);
      end
      applyStimulus(1'b0, 1'b0);
      runSteady("long_release_wait", 6, 4'b1000);
      tick(); checkOutput("long_release_pulse", 4'b0010);
      tick(); checkOutput("long_release_after", 4'b0000);

      // Bounce with all high runs shorter than the window: nothing happens.
      bouncePattern[0] = 4'd1; bouncePattern[1] = 4'd1; bouncePattern[2] = 4'd0;
      bouncePattern[3] = 4'd1; bouncePattern[4] = 4'd0; bouncePattern[5] = 4'd0;
      bouncePattern[6] = 4'd1;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(bouncePattern[i][0], 1'b0);
         tick(); checkOutput("bounce", 4'b0000);
      end
      applyStimulus(1'b0, 1'b0);
      runSteady("bounce_settle", 10, 4'b0000);

      // Press, then a 2-cycle release bounce that must not release, then a clean release.
      applyStimulus(1'b1, 1'b0);
      runSteady("press2_wait", 6, 4'b0000);
      tick(); checkOutput("press2_pulse", 4'b1100);
      tick(); checkOutput("press2_after", 4'b1000);
      applyStimulus(1'b0, 1'b0);
      runSteady("rel_bounce_low", 2, 4'b1000);
      applyStimulus(1'b1, 1'b0);
      runSteady("rel_bounce_high", 2, 4'b1000);
      applyStimulus(1'b0, 1'b0);
      runSteady("release2_wait", 6, 4'b1000);
      tick(); checkOutput("release2_pulse", 4'b0010);
      tick(); checkOutput("release2_after", 4'b0000);

      // Release 7 cycles after press: long press must never fire.
      applyStimulus(1'b1, 1'b0);
      runSteady("press3_wait", 6, 4'b0000);
      tick(); checkOutput("press3_pulse", 4'b1100);
      runSteady("short_hold", 6, 4'b1000);
      applyStimulus(1'b0, 1'b0);
      runSteady("short_release_wait", 6, 4'b1000);
      tick(); checkOutput("short_release_pulse", 4'b0010);
      runSteady("short_no_long", 10, 4'b0000);

      // Reset while in PRESS_WAIT with cnt=2, button kept high.
      applyStimulus(1'b1, 1'b0);
      runSteady("pw_before_reset", 4, 4'b0000);
      applyStimulus(1'b1, 1'b1);
      tick(); checkOutput("mid_reset", 4'b0000);
      applyStimulus(1'b1, 1'b0);
      runSteady("post_reset_wait", 6, 4'b0000);
      tick(); checkOutput("post_reset_press", 4'b1100);
      tick(); checkOutput("post_reset_after", 4'b1000);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
